// File: rtl/sonar_pkg.sv
// Shared HC-SR04 ranging definitions: controller state encoding and default timing
// constants used by both the ranging controller and the echo-width measurer.
package sonar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TRIG = 3'd1,
    ST_WAIT = 3'd2,
    ST_DIV  = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  localparam int unsigned CLK_HZ             = 50_000_000;
  localparam int unsigned TRIG_CYCLES_DEF    = 600;
  localparam int unsigned PERIOD_CYCLES_DEF  = 2_500_000;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1_900_000;
  localparam int unsigned CYC_PER_CM_DEF     = 2900;
  localparam int unsigned MAX_CM_DEF         = 400;

endpackage

// File: rtl/ranger_div.sv
// Restoring divider, 32-bit dividend by a constant divisor, one quotient bit per cycle.
// Latency: done pulses 32 cycles after start; a start while running restarts the divide.
module ranger_div
  import sonar_pkg::*;
#(
  parameter int unsigned DIVISOR = CYC_PER_CM_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  output logic        done,
  output logic [31:0] quotient
);

  localparam logic [32:0] DIV_W = 33'(DIVISOR);

  logic [31:0] rem;
  logic [31:0] quo;
  logic [4:0]  cnt;
  logic        running;
  logic [32:0] rem_sh;
  logic        fits;
  logic [31:0] rem_nx;

  // Remainder always stays below DIVISOR, so the shifted value fits in 33 bits.
  always_comb begin
    rem_sh = {rem, quo[31]};
    fits   = (rem_sh >= DIV_W);
    rem_nx = fits ? 32'(rem_sh - DIV_W) : rem_sh[31:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem     <= '0;
        quo     <= dividend;
        cnt     <= '0;
        running <= 1'b1;
      end else if (running) begin
        rem <= rem_nx;
        quo <= {quo[30:0], fits};
        cnt <= cnt + 1'b1;
        if (cnt == 5'd31) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/sonar_ranger.sv
// HC-SR04 ranging controller: periodic trigger, echo result capture, cm conversion, timeout.
// Latency: range_valid 34 cycles after the meas_valid edge; no backpressure, results are pulses.
module sonar_ranger
  import sonar_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = TRIG_CYCLES_DEF,
  parameter int unsigned PERIOD_CYCLES  = PERIOD_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CYC_PER_CM     = CYC_PER_CM_DEF,
  parameter int unsigned MAX_CM         = MAX_CM_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        trigger,
  input  logic        meas_valid,
  input  logic [31:0] meas_cycles,
  output logic        range_valid,
  output logic [15:0] range_cm,
  output logic        out_of_range,
  output logic        timeout,
  output logic        busy
);

  localparam int TW = $clog2(TRIG_CYCLES) + 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int PW = $clog2(PERIOD_CYCLES) + 1;

  localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD_CYCLES - 1);
  localparam logic [31:0]   MAX_Q     = 32'(MAX_CM);
  localparam logic [15:0]   MAX_RANGE = 16'(MAX_CM);

  state_t state, state_nx;

  logic [TW-1:0] trig_cnt;
  logic [WW-1:0] wait_cnt;
  logic [PW-1:0] per_cnt;
  logic          meas_valid_q;
  logic          meas_edge;
  logic [31:0]   meas_q;
  logic          div_start;
  logic          div_done;
  logic [31:0]   div_quo;

  logic          range_valid_nx;
  logic          timeout_nx;
  logic          out_of_range_nx;
  logic [15:0]   range_cm_nx;

  assign meas_edge = meas_valid & ~meas_valid_q;

  ranger_div #(
    .DIVISOR(CYC_PER_CM)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (meas_q),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_comb begin
    state_nx        = state;
    range_valid_nx  = 1'b0;
    timeout_nx      = 1'b0;
    range_cm_nx     = range_cm;
    out_of_range_nx = out_of_range;
    case (state)
      ST_IDLE: if (enable) state_nx = ST_TRIG;
      ST_TRIG: if (trig_cnt == TRIG_LAST) state_nx = ST_WAIT;
      ST_WAIT: begin
        if (meas_edge) begin
          state_nx = ST_DIV;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx   = ST_HOLD;
          timeout_nx = 1'b1;
        end
      end
      ST_DIV: begin
        if (div_done) begin
          state_nx       = ST_HOLD;
          range_valid_nx = 1'b1;
          if (div_quo > MAX_Q) begin
            range_cm_nx     = MAX_RANGE;
            out_of_range_nx = 1'b1;
          end else begin
            range_cm_nx     = div_quo[15:0];
            out_of_range_nx = 1'b0;
          end
        end
      end
      // >= covers a period that already expired before HOLD was reached.
      ST_HOLD: if (per_cnt >= PER_LAST) state_nx = enable ? ST_TRIG : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      trig_cnt     <= '0;
      wait_cnt     <= '0;
      per_cnt      <= '0;
      meas_valid_q <= 1'b0;
      meas_q       <= '0;
      div_start    <= 1'b0;
      trigger      <= 1'b0;
      busy         <= 1'b0;
      range_valid  <= 1'b0;
      timeout      <= 1'b0;
      range_cm     <= '0;
      out_of_range <= 1'b0;
    end else begin
      state        <= state_nx;
      meas_valid_q <= meas_valid;
      trigger      <= (state_nx == ST_TRIG);
      busy         <= (state_nx != ST_IDLE);
      range_valid  <= range_valid_nx;
      timeout      <= timeout_nx;
      range_cm     <= range_cm_nx;
      out_of_range <= out_of_range_nx;
      div_start    <= (state == ST_WAIT) && meas_edge;
      if ((state == ST_WAIT) && meas_edge) meas_q <= meas_cycles;
      trig_cnt <= (state == ST_TRIG) ? trig_cnt + 1'b1 : '0;
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
      // Period counter restarts on every trigger rise and idles with the controller.
      if ((state_nx == ST_TRIG) && (state != ST_TRIG)) per_cnt <= '0;
      else if (state != ST_IDLE) per_cnt <= per_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sonar_ranger.sv
// Bench for sonar_ranger: time-arithmetic reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sonar_ranger;

  localparam int TRIG = 4;
  localparam int PER  = 200;
  localparam int TOUT = 150;
  localparam int CPC  = 29;
  localparam int MAXC = 400;
  localparam int LAT  = 34;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        trigger;
  logic        meas_valid;
  logic [31:0] meas_cycles;
  logic        range_valid;
  logic [15:0] range_cm;
  logic        out_of_range;
  logic        timeout;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // observation records
  int  rise_last = -1, rise_prev = -1, n_rises = 0, trig_len = -1;
  int  rv_cyc = -1, rv_cnt = 0, to_cyc = -1, to_cnt = 0;
  bit  trig_q = 1'b0;

  // reference model state
  bit m_active = 1'b0, m_done = 1'b0, m_mvq = 1'b0, m_oor = 1'b0, m_res_o = 1'b0;
  int m_rise = 0, m_res_t = -1, m_res_v = 0, m_to_t = -1, m_range = 0;

  sonar_ranger #(
    .TRIG_CYCLES   (TRIG),
    .PERIOD_CYCLES (PER),
    .TIMEOUT_CYCLES(TOUT),
    .CYC_PER_CM    (CPC),
    .MAX_CM        (MAXC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .trigger     (trigger),
    .meas_valid  (meas_valid),
    .meas_cycles (meas_cycles),
    .range_valid (range_valid),
    .range_cm    (range_cm),
    .out_of_range(out_of_range),
    .timeout     (timeout),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Per-cycle reference: trigger windows, result/timeout instants and held range
  // are derived from the rise time and the sampled inputs with plain arithmetic.
  always @(posedge clk) begin : compare
    int  e_trig, e_busy, e_rv, e_to, q;
    bit  edge_s;
    #1;
    cyc++;
    if (!rst) begin
      m_active = 1'b0; m_done = 1'b0; m_mvq = 1'b0;
      m_res_t = -1; m_to_t = -1; m_range = 0; m_oor = 1'b0;
      e_trig = 0; e_busy = 0; e_rv = 0; e_to = 0;
    end else begin
      edge_s = meas_valid && !m_mvq;
      m_mvq  = meas_valid;
      if (!m_active) begin
        if (enable) begin
          m_active = 1'b1; m_rise = cyc; m_done = 1'b0;
        end
      end else if (cyc == m_rise + PER) begin
        if (enable) begin
          m_rise = cyc; m_done = 1'b0;
        end else begin
          m_active = 1'b0;
        end
      end else if (!m_done && cyc > m_rise + TRIG && cyc <= m_rise + TRIG + TOUT) begin
        if (edge_s) begin
          q = int'(meas_cycles / CPC);
          m_done  = 1'b1;
          m_res_t = cyc + LAT;
          m_res_v = (q > MAXC) ? MAXC : q;
          m_res_o = (q > MAXC);
        end else if (cyc == m_rise + TRIG + TOUT) begin
          m_done = 1'b1;
          m_to_t = cyc;
        end
      end
      e_rv = (cyc == m_res_t) ? 1 : 0;
      e_to = (cyc == m_to_t) ? 1 : 0;
      if (e_rv == 1) begin
        m_range = m_res_v;
        m_oor   = m_res_o;
      end
      e_trig = (m_active && (cyc - m_rise) < TRIG) ? 1 : 0;
      e_busy = m_active ? 1 : 0;
    end
    chk("cmp_trigger", int'(trigger), e_trig);
    chk("cmp_busy", int'(busy), e_busy);
    chk("cmp_range_valid", int'(range_valid), e_rv);
    chk("cmp_timeout", int'(timeout), e_to);
    chk("cmp_range_cm", int'(range_cm), m_range);
    chk("cmp_out_of_range", int'(out_of_range), int'(m_oor));

    if (trigger && !trig_q) begin
      rise_prev = rise_last; rise_last = cyc; n_rises++;
    end
    if (!trigger && trig_q) trig_len = cyc - rise_last;
    trig_q = trigger;
    if (range_valid) begin rv_cyc = cyc; rv_cnt++; end
    if (timeout) begin to_cyc = cyc; to_cnt++; end
  end

  task automatic go_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int r, e, c0, nr;
    rst = 1'b0; enable = 1'b0; meas_valid = 1'b0; meas_cycles = '0;
    repeat (3) @(negedge clk);
    chk("rst_trigger", int'(trigger), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_range_cm", int'(range_cm), 0);

    // 1: first trigger and its width
    rst = 1'b1; enable = 1'b1; c0 = cyc;
    go_to(c0 + 10);
    chk("t1_first_rise", rise_last, c0 + 1);
    chk("t1_trig_len", trig_len, 4);
    r = c0 + 1;

    // 2: 290 cycles -> 10 cm, 34-cycle latency
    go_to(r + 19); meas_cycles = 290; meas_valid = 1'b1; e = r + 20;
    go_to(r + 60); meas_valid = 1'b0;
    chk("t2_latency", rv_cyc - e, 34);
    chk("t2_range_cm", int'(range_cm), 10);
    chk("t2_oor", int'(out_of_range), 0);
    chk("t2_single_pulse", rv_cnt, 1);
    go_to(r + 205);
    chk("t1_period", rise_last - rise_prev, 200);
    r = r + 200;

    // 3: no echo -> timeout 150 after trigger fall, range held
    go_to(r + 170);
    chk("t3_timeout_at", to_cyc - r, 154);
    chk("t3_to_count", to_cnt, 1);
    chk("t3_range_held", int'(range_cm), 10);
    go_to(r + 205);
    chk("t3_grid", rise_last - r, 200);
    r = r + 200;

    // 4: saturation and zero
    go_to(r + 29); meas_cycles = 14500; meas_valid = 1'b1; e = r + 30;
    go_to(r + 80); meas_valid = 1'b0;
    chk("t4_sat_range", int'(range_cm), 400);
    chk("t4_sat_oor", int'(out_of_range), 1);
    chk("t4_sat_latency", rv_cyc - e, 34);
    r = r + 200;
    go_to(r + 29); meas_cycles = 0; meas_valid = 1'b1;
    go_to(r + 80); meas_valid = 1'b0;
    chk("t4_zero_range", int'(range_cm), 0);
    chk("t4_zero_oor", int'(out_of_range), 0);
    chk("t4_rv_count", rv_cnt, 3);
    r = r + 200;

    // 5a: level already high when WAIT starts -> timeout
    go_to(r + 1); meas_cycles = 290; meas_valid = 1'b1;
    go_to(r + 170);
    chk("t5_level_timeout", to_cnt, 2);
    chk("t5_level_to_at", to_cyc - r, 154);
    chk("t5_level_no_result", rv_cnt, 3);
    meas_valid = 1'b0;
    r = r + 200;

    // 5b: reset in the middle of a divide
    go_to(r + 19); meas_cycles = 290; meas_valid = 1'b1;
    go_to(r + 30); rst = 1'b0;
    @(posedge clk); #2;
    chk("t5_rst_trigger", int'(trigger), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_range_cm", int'(range_cm), 0);
    chk("t5_rst_range_valid", int'(range_valid), 0);
    @(negedge clk); meas_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; r = cyc + 1;

    // 6: enable dropped in WAIT, measurement still delivered, then idle
    go_to(r + 10); enable = 1'b0;
    go_to(r + 19); meas_cycles = 58; meas_valid = 1'b1; e = r + 20;
    go_to(r + 80); meas_valid = 1'b0;
    chk("t6_range_cm", int'(range_cm), 2);
    chk("t6_latency", rv_cyc - e, 34);
    go_to(r + 199);
    chk("t6_busy_before_end", int'(busy), 1);
    go_to(r + 200);
    chk("t6_busy_at_end", int'(busy), 0);
    nr = n_rises;
    go_to(r + 500);
    chk("t6_no_more_rises", n_rises, nr);
    chk("t6_rv_total", rv_cnt, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
